// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - per-channel writeback FIFOs arbitrated onto one register-file write port
module wb_arbiter #(
    parameter int NUM_CH  = 3,
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          in_oper,
    input  logic [NUM_CH-1:0]          in_writereg,
    input  logic [5*NUM_CH-1:0]        in_regdest,
    input  logic [DATA_W*NUM_CH-1:0]   in_wbvalue,
    output logic [NUM_CH-1:0]          ch_full,
    output logic [NUM_CH-1:0]          ch_overflow,
    output logic                       wb_reg_en,
    output logic [4:0]                 wb_reg_addr,
    output logic [DATA_W-1:0]          wb_reg_data,
    output logic [NUM_CH-1:0]          wb_grant
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EW = 5 + DATA_W;

    logic [EW-1:0]     mem    [NUM_CH][DEPTH];
    logic [AW-1:0]     wr_ptr [NUM_CH];
    logic [AW-1:0]     rd_ptr [NUM_CH];
    logic [AW:0]       count  [NUM_CH];
    logic [NUM_CH-1:0] want;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] nonempty;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     grant_idx;
    logic              grant_any;
    logic [EW-1:0]     head;
    int                arb_idx;

    // A result is only buffered when it really writes a non-zero register.
    always_comb begin
        want     = '0;
        push     = '0;
        pop      = '0;
        nonempty = '0;
        ch_full  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            want[i]     = in_oper[i] & in_writereg[i] & (in_regdest[5*i +: 5] != 5'd0);
            ch_full[i]  = (count[i] == (AW+1)'(DEPTH));
            push[i]     = want[i] & ~ch_full[i];
            nonempty[i] = (count[i] != '0);
            pop[i]      = grant_any && (int'(grant_idx) == i);
        end
    end

    // Loops run backwards so the highest-priority candidate is assigned last.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        arb_idx   = 0;
        if (RR_MODE == 0) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (nonempty[i]) begin
                    grant_any = 1'b1;
                    grant_idx = PW'(i);
                end
            end
        end else begin
            for (int off = NUM_CH; off >= 1; off--) begin
                arb_idx = (int'(rr_ptr) + off) % NUM_CH;
                if (nonempty[arb_idx[PW-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = arb_idx[PW-1:0];
                end
            end
        end
    end

    assign head = mem[grant_idx][rd_ptr[grant_idx]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            ch_overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + {{AW{1'b0}}, push[i]} - {{AW{1'b0}}, pop[i]};
                if (want[i] & ch_full[i])
                    ch_overflow[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i])
                mem[i][wr_ptr[i]] <= {in_regdest[5*i +: 5], in_wbvalue[DATA_W*i +: DATA_W]};
        end
    end

    // Address/data hold on idle cycles; only enable and grant drop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_reg_en   <= 1'b0;
            wb_reg_addr <= '0;
            wb_reg_data <= '0;
            wb_grant    <= '0;
            rr_ptr      <= PW'(NUM_CH - 1);
        end else begin
            wb_reg_en <= grant_any;
            wb_grant  <= pop;
            if (grant_any) begin
                wb_reg_addr <= head[EW-1 -: 5];
                wb_reg_data <= head[DATA_W-1:0];
                rr_ptr      <= grant_idx;
            end
        end
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Parametrised successor to the fixed three-source writeback stage.
- Collects completed results from NUM_CH functional-unit channels (ALU/misc, memory, multiplier, future units). Buffers each channel in its own FIFO. Arbitrates the single register-file write port with either fixed-priority or round-robin selection.
- Drives the register-file write port. Returns per-channel full flags to issue for stall generation.

Parameters:
NUM_CH, 3, number of producer channels (1..8)
DEPTH, 4, entries per channel FIFO (power of two, >=2)
DATA_W, 32, writeback data width
RR_MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round-robin

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_oper  in  NUM_CH  per-channel result-valid strobe, one cycle per result
in_writereg  in  NUM_CH  per-channel register-write request
in_regdest  in  5*NUM_CH  per-channel destination register, channel i at [5i+4:5i]
in_wbvalue  in  DATA_W*NUM_CH  per-channel result, channel i at [DATA_W*i+DATA_W-1:DATA_W*i]
ch_full  out  NUM_CH  channel FIFO holds DEPTH entries (combinational from count)
ch_overflow  out  NUM_CH  sticky flag: a push arrived while the channel was full
wb_reg_en  out  1  register-file write enable (registered)
wb_reg_addr  out  5  register-file write address (registered)
wb_reg_data  out  DATA_W  register-file write data (registered)
wb_grant  out  NUM_CH  one-hot channel granted this write (registered, aligned with wb_reg_en)

Behaviour:
- Reset (async, active-high):
  - All FIFO pointers and counts = 0.
  - ch_full = 0, ch_overflow = 0.
  - wb_reg_en = 0, wb_reg_addr = 0, wb_reg_data = 0, wb_grant = 0.
  - RR pointer = NUM_CH-1, so channel 0 wins first.
  - Reset mid-operation discards all buffered entries.
- Enqueue: at a rising edge, channel i pushes {regdest, wbvalue} iff all of the following hold:
  - in_oper[i] = 1
  - in_writereg[i] = 1
  - regdest != 0
  - the channel was not full before the edge
- Filtered results: in_oper with writereg = 0 or regdest = 0 are discarded silently and never written.
- Overflow: a push while full is dropped, FIFO contents are unchanged, and ch_overflow[i] sets. ch_overflow clears only on reset.
- Full flag: ch_full[i] = (count_i == DEPTH). A pop in the same cycle does not admit a push into a full FIFO; issue must stall on ch_full.
- Arbitration: combinational over non-empty FIFO heads each cycle; at most one pop per cycle.
  - RR_MODE = 0: lowest non-empty index wins.
  - RR_MODE = 1: search starts at (ptr+1) mod NUM_CH and wraps. On a grant, ptr becomes the granted index. With no grant, ptr holds.
- Output register: on each edge with a grant:
  - wb_reg_en = 1; wb_reg_addr and wb_reg_data take the head entry; wb_grant = one-hot of the winner.
  - Otherwise wb_reg_en = 0, wb_grant = 0, and addr/data hold their last values.
- Latency:
  - A result pushed at edge k into an empty, uncontended channel appears with wb_reg_en = 1 after edge k+1.
  - With a simultaneous push and pop on the same channel at one edge, count is unchanged.
- Pointer wrap: FIFO read and write pointers wrap modulo DEPTH. Count is held in log2(DEPTH)+1 bits.
- Ordering: entries within one channel retire in order. No ordering guarantee across channels; issue enforces WAW independently.
- Throughput: one register write per cycle total. Sustained aggregate input above 1 per cycle fills FIFOs and asserts ch_full.

Test Plan:
1. Reset release, single push: ch1 pushes r5 = 0xDEADBEEF at edge 1 -> after edge 2: wb_reg_en = 1, addr = 5, data = 0xDEADBEEF, wb_grant = 3'b010. Following cycle wb_reg_en = 0.
2. Filtering: ch0 pushes with writereg = 0, then with regdest = 0 -> wb_reg_en never asserts and all counts stay 0.
3. Round-robin (RR_MODE = 1): all three channels push at the same edge, then again the next edge -> grants go 0, 1, 2, 0, 1, 2 on consecutive cycles. With RR_MODE = 0 the same stimulus grants 0, 0, 1, 1, 2, 2.
4. Full/overflow (DEPTH = 4): ch2 pushes 5 consecutive values while ch0 is kept non-empty under RR_MODE = 0 -> ch_full[2] = 1 after the 4th push. The 5th push is dropped and ch_overflow[2] = 1. Only 4 values retire for ch2, in push order.
5. Wrap-around: 10 pushes on ch0 at one per two cycles -> all 10 retire in order with correct data, exercising pointer wrap twice.
6. Async reset mid-operation: assert reset between edges with 3 entries buffered -> outputs clear immediately without waiting for an edge. No buffered entry is written after release.
